fms_patch_loader: RTL and testbench

Upstream stage of the convolution core. Accepts a raster-order pixel stream one pixel per cycle with a valid/ready handshake and assembles one FMS_PATCH_SIZE x FMS_PATCH_SIZE patch in a register array. It then presents the patch as the packed `in_fm` vector with `infms_data_vld`, exactly as the convolution core consumes it. The patch is held stable until the consumer accepts it.

---
 rtl/fms_patch_loader.sv | 101 ++++++++++
 tb/tb_fms_patch_loader.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fms_patch_loader.sv
// Raster pixel stream -> one P*P patch held in a register array; valid rises the cycle after the last accept.
// Backpressure: pix_rdy drops while the completed patch waits for infms_data_rdy; the patch is frozen until hand-off.
module fms_patch_loader #(
    parameter int FMS_PATCH_SIZE   = 8,
    parameter int INFMS_DATA_WIDTH = 8
) (
    input  logic                                                    clk,
    input  logic                                                    rst_n,
    input  logic [INFMS_DATA_WIDTH-1:0]                             pix_in,
    input  logic                                                    pix_sof,
    input  logic                                                    pix_vld,
    output logic                                                    pix_rdy,
    output logic [FMS_PATCH_SIZE*FMS_PATCH_SIZE*INFMS_DATA_WIDTH-1:0] in_fm,
    output logic                                                    infms_data_vld,
    input  logic                                                    infms_data_rdy,
    output logic                                                    sof_err,
    output logic [15:0]                                             patch_cnt
);
    localparam int NPIX  = FMS_PATCH_SIZE * FMS_PATCH_SIZE;
    localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

    typedef enum logic {FILL, FULL} state_t;

    state_t                      state, state_n;
    logic [IDX_W-1:0]            wr_idx, idx_n, wr_addr;
    logic                        wr_en, err_set, cnt_inc, accept;
    logic                        run;
    logic [INFMS_DATA_WIDTH-1:0] mem [NPIX];

    // run holds pix_rdy low while reset is asserted and releases it on the first edge after.
    assign pix_rdy        = run & (state == FILL);
    assign infms_data_vld = (state == FULL);
    assign accept         = pix_vld & pix_rdy;

    always_comb begin
        state_n = state;
        idx_n   = wr_idx;
        wr_addr = '0;
        wr_en   = 1'b0;
        err_set = 1'b0;
        cnt_inc = 1'b0;
        case (state)
            FILL: begin
                if (accept) begin
                    if (pix_sof) begin
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        idx_n   = IDX_W'(1);
                        err_set = (wr_idx != '0);
                    end else if (wr_idx != '0) begin
                        wr_en   = 1'b1;
                        wr_addr = wr_idx;
                        if (wr_idx == LAST_IDX) begin
                            idx_n   = '0;
                            state_n = FULL;
                        end else begin
                            idx_n = wr_idx + IDX_W'(1);
                        end
                    end
                end
            end
            FULL: begin
                if (infms_data_rdy) begin
                    state_n = FILL;
                    cnt_inc = 1'b1;
                end
            end
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            wr_idx    <= '0;
            run       <= 1'b0;
            sof_err   <= 1'b0;
            patch_cnt <= '0;
        end else begin
            state     <= state_n;
            wr_idx    <= idx_n;
            run       <= 1'b1;
            sof_err   <= sof_err | err_set;
            patch_cnt <= patch_cnt + (cnt_inc ? 16'd1 : 16'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPIX; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= pix_in;
        end
    end

    for (genvar g = 0; g < NPIX; g++) begin : g_view
        assign in_fm[(g+1)*INFMS_DATA_WIDTH-1 -: INFMS_DATA_WIDTH] = mem[g];
    end

endmodule

// File: tb/tb_fms_patch_loader.sv
// Directed bench for fms_patch_loader: reset, fill, backpressure, alignment, resync, mid-fill reset.
module tb_fms_patch_loader;
    localparam int P = 8;
    localparam int W = 8;
    localparam int N = P * P;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [W-1:0]     pix_in;
    logic             pix_sof;
    logic             pix_vld;
    logic             pix_rdy;
    logic [N*W-1:0]   in_fm;
    logic             infms_data_vld;
    logic             infms_data_rdy;
    logic             sof_err;
    logic [15:0]      patch_cnt;

    int               checks = 0;
    int               failures = 0;
    logic [N*W-1:0]   exp_fm;
    logic [N*W-1:0]   held_fm;

    always #5 clk = ~clk;

    fms_patch_loader #(.FMS_PATCH_SIZE(P), .INFMS_DATA_WIDTH(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pix_in         (pix_in),
        .pix_sof        (pix_sof),
        .pix_vld        (pix_vld),
        .pix_rdy        (pix_rdy),
        .in_fm          (in_fm),
        .infms_data_vld (infms_data_vld),
        .infms_data_rdy (infms_data_rdy),
        .sof_err        (sof_err),
        .patch_cnt      (patch_cnt)
    );

    task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pixel per cycle: drive at negedge, the DUT samples at the following posedge.
    task automatic send(input logic [W-1:0] v, input logic sof);
        @(negedge clk);
        pix_in  = v;
        pix_sof = sof;
        pix_vld = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        pix_vld = 1'b0;
        pix_sof = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic build_exp(input logic [W-1:0] base);
        for (int i = 0; i < N; i++) exp_fm[i*W +: W] = base + W'(i);
    endtask

    task automatic send_patch(input logic [W-1:0] base);
        for (int i = 0; i < N; i++) send(base + W'(i), (i == 0));
    endtask

    initial begin
        rst_n = 1'b0; pix_in = '0; pix_sof = 1'b0; pix_vld = 1'b0; infms_data_rdy = 1'b0;
        #23;
        chk("rst_pix_rdy",  N*W'(pix_rdy),        '0);
        chk("rst_vld",      N*W'(infms_data_vld), '0);
        chk("rst_in_fm",    in_fm,                '0);
        chk("rst_sof_err",  N*W'(sof_err),        '0);
        chk("rst_patch_cnt",N*W'(patch_cnt),      '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_pix_rdy", N*W'(pix_rdy), N*W'(1));

        // Basic fill with consumer always ready.
        infms_data_rdy = 1'b1;
        send_patch(8'h00);
        build_exp(8'h00);
        chk("basic_vld",     N*W'(infms_data_vld), N*W'(1));
        chk("basic_in_fm",   in_fm,                exp_fm);
        chk("basic_pix_rdy", N*W'(pix_rdy),        '0);
        idle_cycle();
        chk("basic_handoff_vld", N*W'(infms_data_vld), '0);
        chk("basic_patch_cnt",   N*W'(patch_cnt),      N*W'(1));
        chk("basic_rdy_again",   N*W'(pix_rdy),        N*W'(1));

        // No-gap refill, then backpressure with pix_vld still asserted.
        infms_data_rdy = 1'b0;
        send_patch(8'h40);
        build_exp(8'h40);
        chk("bp_vld",   N*W'(infms_data_vld), N*W'(1));
        chk("bp_in_fm", in_fm,                exp_fm);
        held_fm = exp_fm;
        for (int c = 0; c < 10; c++) begin
            send(8'hEE, (c == 3));
            chk("bp_pix_rdy_low", N*W'(pix_rdy), '0);
            chk("bp_in_fm_held",  in_fm,         held_fm);
        end
        chk("bp_cnt_before", N*W'(patch_cnt), N*W'(1));
        @(negedge clk); pix_vld = 1'b0; infms_data_rdy = 1'b1;
        @(posedge clk); #1;
        chk("bp_handoff_vld", N*W'(infms_data_vld), '0);
        chk("bp_patch_cnt",   N*W'(patch_cnt),      N*W'(2));
        chk("bp_sof_err",     N*W'(sof_err),        '0);

        // Alignment: leading non-SOF pixels are dropped.
        for (int i = 0; i < 5; i++) send(8'h11 + W'(i), 1'b0);
        chk("align_no_vld", N*W'(infms_data_vld), '0);
        infms_data_rdy = 1'b0;
        send_patch(8'h80);
        build_exp(8'h80);
        chk("align_vld",   N*W'(infms_data_vld), N*W'(1));
        chk("align_el0",   N*W'(in_fm[7:0]),     N*W'(8'h80));
        chk("align_el63",  N*W'(in_fm[N*W-1 -: W]), N*W'(8'hBF));
        chk("align_in_fm", in_fm,                exp_fm);
        chk("align_sof_err", N*W'(sof_err),      '0);
        @(negedge clk); pix_vld = 1'b0; infms_data_rdy = 1'b1;
        @(posedge clk); #1;
        chk("align_patch_cnt", N*W'(patch_cnt), N*W'(3));

        // Mid-patch resync: 20 pixels, then a fresh SOF frame.
        for (int i = 0; i < 20; i++) send(8'h55, (i == 0));
        chk("resync_pre_err", N*W'(sof_err), '0);
        for (int i = 0; i < N - 1; i++) send(8'hC0 + W'(i), (i == 0));
        chk("resync_sof_err",   N*W'(sof_err),        N*W'(1));
        chk("resync_vld_early", N*W'(infms_data_vld), '0);
        infms_data_rdy = 1'b0;
        send(8'hFF, 1'b0);
        build_exp(8'hC0);
        chk("resync_vld",   N*W'(infms_data_vld), N*W'(1));
        chk("resync_in_fm", in_fm,                exp_fm);
        @(negedge clk); pix_vld = 1'b0; infms_data_rdy = 1'b1;
        @(posedge clk); #1;
        chk("resync_patch_cnt",  N*W'(patch_cnt), N*W'(4));
        chk("resync_err_sticky", N*W'(sof_err),   N*W'(1));

        // Reset in the middle of a fill.
        for (int i = 0; i < 30; i++) send(8'h01 + W'(i), (i == 0));
        @(negedge clk); pix_vld = 1'b0; rst_n = 1'b0;
        #2;
        chk("mrst_vld",       N*W'(infms_data_vld), '0);
        chk("mrst_in_fm",     in_fm,                '0);
        chk("mrst_sof_err",   N*W'(sof_err),        '0);
        chk("mrst_patch_cnt", N*W'(patch_cnt),      '0);
        chk("mrst_pix_rdy",   N*W'(pix_rdy),        '0);
        @(negedge clk); rst_n = 1'b1; infms_data_rdy = 1'b0;
        @(posedge clk); #1;
        chk("mrst_rdy_back", N*W'(pix_rdy), N*W'(1));
        send_patch(8'h20);
        build_exp(8'h20);
        chk("mrst_full_vld", N*W'(infms_data_vld), N*W'(1));
        chk("mrst_full_fm",  in_fm,                exp_fm);
        @(negedge clk); pix_vld = 1'b0; infms_data_rdy = 1'b1;
        @(posedge clk); #1;
        chk("mrst_patch_cnt_after", N*W'(patch_cnt), N*W'(1));
        chk("mrst_vld_after",       N*W'(infms_data_vld), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
